// File: rtl/uart_pkg.sv
// Shared receive-path definitions: entry layout, data-size encoding, data extraction.
// Latency: n/a (constants and a combinational helper).
// Backpressure: n/a.
package uart_pkg;

  // Receive entry layout: {fe, pe, data[7:0]}
  localparam int ENTRY_W = 10;
  localparam int FE_POS  = 9;
  localparam int PE_POS  = 8;

  // Data-size encoding of the control register bit
  localparam logic DS_7BIT = 1'b0;
  localparam logic DS_8BIT = 1'b1;

  // Pull the data field out of an aligned frame; 7-bit mode clears bit 7
  function automatic logic [7:0] rx_data(input logic [10:0] frame, input logic ds);
    return (ds == DS_8BIT) ? frame[7:0] : {1'b0, frame[6:0]};
  endfunction

endpackage

// File: rtl/rx_fifo.sv
// Generic synchronous FIFO with flush and first-word-fall-through head output.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push while full is accepted only together with an effective pop; pop while empty is ignored.
module rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO can still accept a write when the head is leaving in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; no reset needed since validity is tracked by count
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush and reset take precedence
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_controller.sv
// Receive controller: captures frontend frames into a FIFO, exposes head/status, overrun and interrupt.
// Latency: frame pulse at N -> head/status in N+1, irq in N+2; pop at N -> next head in N+1.
// Backpressure: none upstream; a frame arriving while full without a same-cycle read is dropped and flags overrun.
module rx_controller
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [10:0] frame_i,
  input  logic        parity_err_i,
  input  logic        frame_err_i,
  input  logic        frame_valid_i,
  input  logic        cr_rxen_i,
  input  logic        cr_ds_i,
  input  logic        cr_rxneie_i,
  input  logic        cr_oeie_i,
  input  logic        rd_i,
  input  logic        flush_i,
  input  logic        clr_oe_i,
  output logic [7:0]  rxdr_o,
  output logic        sr_rxne_o,
  output logic        sr_rxf_o,
  output logic        sr_pe_o,
  output logic        sr_fe_o,
  output logic        sr_oe_o,
  output logic        irq_o
);

  logic                          frame_req;
  logic                          push;
  logic                          overrun;
  logic                          full;
  logic                          empty;
  logic [ENTRY_W-1:0]            wr_entry;
  logic [ENTRY_W-1:0]            head;
  logic [$clog2(FIFO_DEPTH):0]   fill_level_unused;
  logic                          unused_frame_bits;

  // Upper frame bits carry no data in either size mode
  assign unused_frame_bits = ^frame_i[10:8];

  assign frame_req = frame_valid_i & cr_rxen_i;
  // A read in the same cycle frees the head slot, so a full FIFO can still take the frame
  assign push      = frame_req & (~full | rd_i);
  assign overrun   = frame_req & full & ~rd_i;
  assign wr_entry  = {frame_err_i, parity_err_i, rx_data(frame_i, cr_ds_i)};

  rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (rd_i),
    .flush (flush_i),
    .wdata (wr_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fill_level_unused)
  );

  // Head fields are forced to zero when nothing is stored
  assign sr_rxne_o = ~empty;
  assign sr_rxf_o  = full;
  assign rxdr_o    = empty ? 8'h00 : head[7:0];
  assign sr_pe_o   = ~empty & head[PE_POS];
  assign sr_fe_o   = ~empty & head[FE_POS];

  // Sticky overrun: flush clears, a new overrun beats a coincident clear
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      sr_oe_o <= 1'b0;
    end else if (overrun) begin
      sr_oe_o <= 1'b1;
    end else if (clr_oe_i) begin
      sr_oe_o <= 1'b0;
    end
  end

  // Interrupt request registered one stage behind the status it reflects
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_o <= 1'b0;
    end else begin
      irq_o <= (sr_rxne_o & cr_rxneie_i) | (sr_oe_o & cr_oeie_i);
    end
  end

endmodule

// File: tb/tb_rx_controller.sv
// Directed bench for rx_controller: vector table plus hand-written multi-cycle sequences.
// Latency: inputs driven at negedge, outputs checked at the following negedge.
// Backpressure: n/a.
module tb_rx_controller;

  logic        clk;
  logic        rst;
  logic [10:0] frame;
  logic        parity_err;
  logic        frame_err;
  logic        frame_valid;
  logic        rxen;
  logic        ds;
  logic        rxneie;
  logic        oeie;
  logic        rd;
  logic        flush;
  logic        clr_oe;
  logic [7:0]  rxdr;
  logic        rxne;
  logic        rxf;
  logic        pe;
  logic        fe;
  logic        oe;
  logic        irq;

  int tests;
  int errors;

  rx_controller #(.FIFO_DEPTH(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .frame_i       (frame),
    .parity_err_i  (parity_err),
    .frame_err_i   (frame_err),
    .frame_valid_i (frame_valid),
    .cr_rxen_i     (rxen),
    .cr_ds_i       (ds),
    .cr_rxneie_i   (rxneie),
    .cr_oeie_i     (oeie),
    .rd_i          (rd),
    .flush_i       (flush),
    .clr_oe_i      (clr_oe),
    .rxdr_o        (rxdr),
    .sr_rxne_o     (rxne),
    .sr_rxf_o      (rxf),
    .sr_pe_o       (pe),
    .sr_fe_o       (fe),
    .sr_oe_o       (oe),
    .irq_o         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [10:0] frame;
    logic        pe_in;
    logic        fe_in;
    logic        rxen;
    logic        ds;
    logic        rxneie;
    logic        rd;
    logic [7:0]  e_rxdr;
    logic        e_rxne;
    logic        e_pe;
    logic        e_fe;
    logic        e_irq;
  } vec_t;

  vec_t vecs[19];

  function automatic vec_t mk(input logic fv, input logic [10:0] f, input logic pi, input logic fi,
                              input logic en, input logic d, input logic ie, input logic r,
                              input logic [7:0] erx, input logic ene, input logic epe,
                              input logic efe, input logic eirq);
    vec_t v;
    v.fv = fv; v.frame = f; v.pe_in = pi; v.fe_in = fi; v.rxen = en; v.ds = d;
    v.rxneie = ie; v.rd = r; v.e_rxdr = erx; v.e_rxne = ene; v.e_pe = epe;
    v.e_fe = efe; v.e_irq = eirq;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One cycle of frame/read/flush/clear activity, then inputs return to idle
  task automatic cyc(input logic fv, input logic [10:0] f, input logic r,
                     input logic fl, input logic clr);
    frame_valid = fv; frame = f; rd = r; flush = fl; clr_oe = clr;
    step();
    frame_valid = 1'b0; rd = 1'b0; flush = 1'b0; clr_oe = 1'b0;
  endtask

  // Reference queue for the wrap-around run
  logic [7:0] q[$];

  task automatic mcyc(input logic fv, input logic [7:0] d, input logic r, input string nm);
    if (r && q.size() > 0) void'(q.pop_front());
    if (fv && q.size() < 8) q.push_back(d);
    cyc(fv, {3'b000, d}, r, 1'b0, 1'b0);
    chk({nm, " rxdr"}, rxdr, (q.size() > 0) ? q[0] : 8'h00);
    chk({nm, " rxne"}, {7'b0, rxne}, {7'b0, (q.size() > 0) ? 1'b1 : 1'b0});
  endtask

  logic [7:0] exp_seq [9];

  initial begin
    tests = 0; errors = 0;
    rst = 1'b1; frame = '0; parity_err = 0; frame_err = 0; frame_valid = 0;
    rxen = 1'b1; ds = 1'b1; rxneie = 1'b0; oeie = 1'b0; rd = 0; flush = 0; clr_oe = 0;

    // fv frame pe fe rxen ds ie rd | rxdr rxne pe fe irq
    vecs[0]  = mk(1, 11'h0A5, 0, 0, 1, 1, 1, 0, 8'hA5, 1, 0, 0, 0);
    vecs[1]  = mk(0, 11'h000, 0, 0, 1, 1, 1, 0, 8'hA5, 1, 0, 0, 1);
    vecs[2]  = mk(0, 11'h000, 0, 0, 1, 1, 1, 1, 8'h00, 0, 0, 0, 1);
    vecs[3]  = mk(0, 11'h000, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    vecs[4]  = mk(1, 11'h0FF, 0, 0, 1, 0, 1, 0, 8'h7F, 1, 0, 0, 0);
    vecs[5]  = mk(1, 11'h012, 1, 0, 1, 1, 1, 1, 8'h12, 1, 1, 0, 1);
    vecs[6]  = mk(1, 11'h034, 0, 1, 1, 1, 1, 0, 8'h12, 1, 1, 0, 1);
    vecs[7]  = mk(0, 11'h000, 0, 0, 1, 1, 1, 1, 8'h34, 1, 0, 1, 1);
    vecs[8]  = mk(0, 11'h000, 0, 0, 1, 1, 1, 1, 8'h00, 0, 0, 0, 1);
    vecs[9]  = mk(0, 11'h000, 0, 0, 1, 1, 1, 1, 8'h00, 0, 0, 0, 0);
    vecs[10] = mk(1, 11'h0AA, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    vecs[11] = mk(1, 11'h03C, 0, 0, 1, 1, 0, 0, 8'h3C, 1, 0, 0, 0);
    vecs[12] = mk(0, 11'h000, 0, 0, 1, 1, 0, 0, 8'h3C, 1, 0, 0, 0);
    vecs[13] = mk(0, 11'h000, 0, 0, 0, 1, 1, 0, 8'h3C, 1, 0, 0, 1);
    vecs[14] = mk(0, 11'h000, 0, 0, 1, 1, 1, 1, 8'h00, 0, 0, 0, 1);
    vecs[15] = mk(0, 11'h000, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0);
    vecs[16] = mk(1, 11'h1D5, 0, 0, 1, 0, 1, 0, 8'h55, 1, 0, 0, 0);
    vecs[17] = mk(0, 11'h000, 0, 0, 1, 1, 1, 1, 8'h00, 0, 0, 0, 1);
    vecs[18] = mk(0, 11'h000, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, 0, 0);

    step(); step();
    chk("reset rxdr", rxdr, 8'h00);
    chk("reset rxne", {7'b0, rxne}, 8'h00);
    chk("reset rxf",  {7'b0, rxf},  8'h00);
    chk("reset pe",   {7'b0, pe},   8'h00);
    chk("reset fe",   {7'b0, fe},   8'h00);
    chk("reset oe",   {7'b0, oe},   8'h00);
    chk("reset irq",  {7'b0, irq},  8'h00);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      frame_valid = vecs[i].fv; frame = vecs[i].frame; parity_err = vecs[i].pe_in;
      frame_err = vecs[i].fe_in; rxen = vecs[i].rxen; ds = vecs[i].ds;
      rxneie = vecs[i].rxneie; rd = vecs[i].rd;
      step();
      chk($sformatf("vec%0d rxdr", i), rxdr, vecs[i].e_rxdr);
      chk($sformatf("vec%0d rxne", i), {7'b0, rxne}, {7'b0, vecs[i].e_rxne});
      chk($sformatf("vec%0d pe", i),   {7'b0, pe},   {7'b0, vecs[i].e_pe});
      chk($sformatf("vec%0d fe", i),   {7'b0, fe},   {7'b0, vecs[i].e_fe});
      chk($sformatf("vec%0d irq", i),  {7'b0, irq},  {7'b0, vecs[i].e_irq});
      chk($sformatf("vec%0d oe", i),   {7'b0, oe},   8'h00);
    end
    frame_valid = 0; parity_err = 0; frame_err = 0; rd = 0;
    rxen = 1'b1; ds = 1'b1; rxneie = 1'b0; oeie = 1'b1;

    // Fill to full, overrun on the ninth frame, drain in order, clear overrun
    for (int i = 1; i <= 8; i++) cyc(1'b1, 11'(i), 1'b0, 1'b0, 1'b0);
    chk("fill rxf", {7'b0, rxf}, 8'h01);
    chk("fill oe",  {7'b0, oe},  8'h00);
    chk("fill head", rxdr, 8'h01);
    cyc(1'b1, 11'h009, 1'b0, 1'b0, 1'b0);
    chk("ovr oe", {7'b0, oe}, 8'h01);
    chk("ovr rxf", {7'b0, rxf}, 8'h01);
    chk("ovr irq early", {7'b0, irq}, 8'h00);
    step();
    chk("ovr irq", {7'b0, irq}, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain%0d", i), rxdr, 8'(i));
      cyc(1'b0, 11'h000, 1'b1, 1'b0, 1'b0);
    end
    chk("drain empty", {7'b0, rxne}, 8'h00);
    chk("drain no 09", rxdr, 8'h00);
    chk("oe sticky", {7'b0, oe}, 8'h01);
    cyc(1'b0, 11'h000, 1'b0, 1'b0, 1'b1);
    chk("clr oe", {7'b0, oe}, 8'h00);
    oeie = 1'b0;

    // Full FIFO with push and read in the same cycle: slot reuse, no overrun
    for (int i = 0; i < 8; i++) cyc(1'b1, 11'(8'h11 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 11'h055, 1'b1, 1'b0, 1'b0);
    chk("pushpop oe",  {7'b0, oe},  8'h00);
    chk("pushpop rxf", {7'b0, rxf}, 8'h01);
    chk("pushpop head", rxdr, 8'h12);
    exp_seq = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h55, 8'h00};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("reuse%0d", i), rxdr, exp_seq[i]);
      cyc(1'b0, 11'h000, 1'b1, 1'b0, 1'b0);
    end
    chk("reuse empty", rxdr, exp_seq[8]);

    // Pointer wrap: 20 simultaneous push/pop cycles against a reference queue
    q.delete();
    mcyc(1'b1, 8'h80, 1'b0, "wrap pre");
    for (int i = 0; i < 20; i++) mcyc(1'b1, 8'(8'h81 + i), 1'b1, $sformatf("wrap%0d", i));
    mcyc(1'b0, 8'h00, 1'b1, "wrap end");

    // Flush with five entries, overrun pending and a same-cycle push
    for (int i = 0; i < 8; i++) cyc(1'b1, 11'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 11'h099, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 11'h000, 1'b1, 1'b0, 1'b0);
    chk("pre-flush head", rxdr, 8'h23);
    chk("pre-flush oe", {7'b0, oe}, 8'h01);
    cyc(1'b1, 11'h077, 1'b0, 1'b1, 1'b0);
    chk("flush rxne", {7'b0, rxne}, 8'h00);
    chk("flush rxf",  {7'b0, rxf},  8'h00);
    chk("flush oe",   {7'b0, oe},   8'h00);
    chk("flush rxdr", rxdr, 8'h00);
    cyc(1'b1, 11'h066, 1'b0, 1'b0, 1'b0);
    chk("post-flush head", rxdr, 8'h66);
    cyc(1'b0, 11'h000, 1'b1, 1'b0, 1'b0);

    // Reset with three stored entries and a frame arriving on the reset edge
    rxneie = 1'b1;
    for (int i = 1; i <= 3; i++) cyc(1'b1, 11'(i), 1'b0, 1'b0, 1'b0);
    step();
    chk("pre-rst irq", {7'b0, irq}, 8'h01);
    rst = 1'b1;
    cyc(1'b1, 11'h044, 1'b0, 1'b0, 1'b0);
    chk("rst rxdr", rxdr, 8'h00);
    chk("rst rxne", {7'b0, rxne}, 8'h00);
    chk("rst rxf",  {7'b0, rxf},  8'h00);
    chk("rst pe",   {7'b0, pe},   8'h00);
    chk("rst fe",   {7'b0, fe},   8'h00);
    chk("rst oe",   {7'b0, oe},   8'h00);
    chk("rst irq",  {7'b0, irq},  8'h00);
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
